// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-master external SRAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sram_arb_pkg;

    // Command latched at grant time; drives the SRAM pins for the whole access.
    typedef struct packed {
        logic        we;
        logic [19:0] addr;
        logic [15:0] wdata;
    } sram_cmd_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } arb_state_t;

    // Pin modes, packed as {WE_N, CE_N, OE_N, LB_N, UB_N}; both byte lanes always enabled.
    localparam logic [4:0] SRAM_NOT_SELECT = 5'b11100;
    localparam logic [4:0] SRAM_READ       = 5'b10000;
    localparam logic [4:0] SRAM_WRITE      = 5'b00100;

    localparam logic OWNER_M0 = 1'b0;
    localparam logic OWNER_M1 = 1'b1;

endpackage

// File: rtl/sram_arb_pick.sv
// Grant decision between M0 (priority) and M1 with a bounded M0 streak.
// Latency: grants are combinational in the enable cycle; streak updates on the clock.
// Backpressure: grants only while gnt_en_i is high; losing requests simply wait.
module sram_arb_pick
    import sram_arb_pkg::*;
#(
    parameter int MAX_M0_BURST = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic req0_i,
    input  logic req1_i,
    input  logic gnt_en_i,
    output logic gnt0_o,
    output logic gnt1_o
);

    logic [3:0] streak_q, streak_d;
    logic       m1_turn;

    // M1 overrides M0 only once M0 has used up its streak allowance while M1 waited.
    assign m1_turn = req0_i && req1_i && (streak_q == 4'(MAX_M0_BURST));
    assign gnt1_o  = gnt_en_i && req1_i && (!req0_i || m1_turn);
    assign gnt0_o  = gnt_en_i && req0_i && !m1_turn;

    // Count M0 grants taken while M1 is waiting; any M1 grant or uncontested M0 grant clears it.
    always_comb begin
        streak_d = streak_q;
        if (gnt1_o) begin
            streak_d = '0;
        end else if (gnt0_o) begin
            if (!req1_i) begin
                streak_d = '0;
            end else if (streak_q < 4'(MAX_M0_BURST)) begin
                streak_d = streak_q + 4'd1;
            end
        end
    end

    // Streak register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one async 16-bit SRAM between M0 (real-time) and M1 via fixed-length accesses.
// Latency: gnt at t, pins active t+1..t+ACCESS_CYCLES, done (and read data) at t+ACCESS_CYCLES+1.
// Backpressure: requesters hold req until gnt; no new grant while an access is in flight.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ACCESS_CYCLES = 2,
    parameter int MAX_M0_BURST  = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_m0_req,
    input  logic        i_m0_we,
    input  logic [19:0] i_m0_addr,
    input  logic [15:0] i_m0_wdata,
    output logic        o_m0_gnt,
    output logic        o_m0_done,
    output logic [15:0] o_m0_rdata,
    input  logic        i_m1_req,
    input  logic        i_m1_we,
    input  logic [19:0] i_m1_addr,
    input  logic [15:0] i_m1_wdata,
    output logic        o_m1_gnt,
    output logic        o_m1_done,
    output logic [15:0] o_m1_rdata,
    output logic        o_busy,
    inout  wire  [15:0] SRAM_DQ,
    output logic [19:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_UB_N
);

    arb_state_t  state_q, state_d;
    sram_cmd_t   cmd_q, cmd_d;
    sram_cmd_t   m0_cmd, m1_cmd, win_cmd;
    logic        owner_q, owner_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [4:0]  pins_q, pins_d;
    logic        dq_oe_q, dq_oe_d;
    logic        done0_q, done0_d, done1_q, done1_d;
    logic [15:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic        gnt0, gnt1;

    sram_arb_pick #(
        .MAX_M0_BURST(MAX_M0_BURST)
    ) u_pick (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .req0_i  (i_m0_req),
        .req1_i  (i_m1_req),
        .gnt_en_i(state_q == IDLE),
        .gnt0_o  (gnt0),
        .gnt1_o  (gnt1)
    );

    assign m0_cmd  = '{we: i_m0_we, addr: i_m0_addr, wdata: i_m0_wdata};
    assign m1_cmd  = '{we: i_m1_we, addr: i_m1_addr, wdata: i_m1_wdata};
    assign win_cmd = gnt1 ? m1_cmd : m0_cmd;

    // Next-state: latch the winner in IDLE, count down the access, release pins on the last cycle.
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        pins_d   = pins_q;
        dq_oe_d  = dq_oe_q;
        done0_d  = 1'b0;
        done1_d  = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            IDLE: begin
                if (gnt0 || gnt1) begin
                    owner_d = gnt1 ? OWNER_M1 : OWNER_M0;
                    cmd_d   = win_cmd;
                    cnt_d   = 3'(ACCESS_CYCLES - 1);
                    pins_d  = win_cmd.we ? SRAM_WRITE : SRAM_READ;
                    dq_oe_d = win_cmd.we;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == 3'd0) begin
                    // Read data is sampled while OE_N is still low, before the pins deselect.
                    if (!cmd_q.we) begin
                        if (owner_q == OWNER_M1) begin
                            rdata1_d = SRAM_DQ;
                        end else begin
                            rdata0_d = SRAM_DQ;
                        end
                    end
                    done0_d = (owner_q == OWNER_M0);
                    done1_d = (owner_q == OWNER_M1);
                    pins_d  = SRAM_NOT_SELECT;
                    dq_oe_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and pin registers; reset deselects the SRAM and floats DQ immediately.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            cmd_q    <= '0;
            owner_q  <= OWNER_M0;
            cnt_q    <= '0;
            pins_q   <= SRAM_NOT_SELECT;
            dq_oe_q  <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            pins_q   <= pins_d;
            dq_oe_q  <= dq_oe_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign o_m0_gnt   = gnt0;
    assign o_m1_gnt   = gnt1;
    assign o_m0_done  = done0_q;
    assign o_m1_done  = done1_q;
    assign o_m0_rdata = rdata0_q;
    assign o_m1_rdata = rdata1_q;
    assign o_busy     = (state_q != IDLE);

    assign SRAM_ADDR = cmd_q.addr;
    assign {SRAM_WE_N, SRAM_CE_N, SRAM_OE_N, SRAM_LB_N, SRAM_UB_N} = pins_q;
    // DQ is only ever driven during a write access, so the done/idle cycle is always a turnaround gap.
    assign SRAM_DQ = dq_oe_q ? cmd_q.wdata : 16'hzzzz;

endmodule

// File: tb/tb_sram_arbiter.sv
`timescale 1ns/1ps
module tb_sram_arbiter;
    import sram_arb_pkg::*;

    localparam int MB = 4;

    int n_tests = 0;
    int n_fail  = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          m;
        int          dcyc;
        logic        rd;
        logic [15:0] data;
    } exp_t;

    function automatic void check(input int cfg, input string name,
                                  input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL cfg%0d %s: got 0x%0h, expected 0x%0h (t=%0t)", cfg, name, act, exp, $time);
        end
    endfunction

    // Two configurations run side by side: ACCESS_CYCLES=2 and ACCESS_CYCLES=1.
    for (genvar g = 0; g < 2; g++) begin : cfg
        localparam int AC = (g == 0) ? 2 : 1;

        logic        rst;
        logic        req   [2];
        logic        we    [2];
        logic [19:0] addr  [2];
        logic [15:0] wdata [2];
        logic        gnt   [2];
        logic        done  [2];
        logic [15:0] rdata [2];
        logic        busy;
        wire  [15:0] dq;
        logic [19:0] sa;
        logic        we_n, ce_n, oe_n, lb_n, ub_n;
        logic [4:0]  pins;
        logic        fin_l = 1'b0;
        int          cyc = 0;

        // Bench-side bookkeeping (reference model state)
        exp_t        expq[$];
        logic [15:0] ref_mem [int];
        logic [15:0] held [2];
        logic [19:0] wlist[$];
        int          gnt_log[$];
        int          last_gnt [2];
        int          last_done [2];
        int          run, nfree, act_s, act_e;
        logic        act_we;
        logic [19:0] act_a;
        logic [15:0] act_d;

        sram_arbiter #(.ACCESS_CYCLES(AC), .MAX_M0_BURST(MB)) dut (
            .i_clk(clk), .i_rst(rst),
            .i_m0_req(req[0]), .i_m0_we(we[0]), .i_m0_addr(addr[0]), .i_m0_wdata(wdata[0]),
            .o_m0_gnt(gnt[0]), .o_m0_done(done[0]), .o_m0_rdata(rdata[0]),
            .i_m1_req(req[1]), .i_m1_we(we[1]), .i_m1_addr(addr[1]), .i_m1_wdata(wdata[1]),
            .o_m1_gnt(gnt[1]), .o_m1_done(done[1]), .o_m1_rdata(rdata[1]),
            .o_busy(busy), .SRAM_DQ(dq), .SRAM_ADDR(sa),
            .SRAM_WE_N(we_n), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
            .SRAM_LB_N(lb_n), .SRAM_UB_N(ub_n)
        );

        assign pins = {we_n, ce_n, oe_n, lb_n, ub_n};

        // SRAM device: async read drive, write captured while CE_N and WE_N are low.
        logic [15:0] mem [0:1048575];
        assign dq = (!ce_n && !oe_n && we_n) ? mem[sa] : 16'hzzzz;
        always @(posedge clk) begin
            cyc <= cyc + 1;
            if (!ce_n && !we_n) mem[sa] <= dq;
        end

        // Monitor / scoreboard: predicts grants from the arbitration rules, then checks pins, dones, rdata.
        initial begin
            exp_t e;
            int   w;
            logic idle;
            run = 0; nfree = 0; act_s = -1; act_e = -2;
            held[0] = '0; held[1] = '0;
            last_gnt[0] = 0; last_gnt[1] = 0; last_done[0] = 0; last_done[1] = 0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    expq.delete();
                    run = 0; nfree = 0; act_e = -2;
                    held[0] = '0; held[1] = '0;
                    check(g, "rst_pins", pins, SRAM_NOT_SELECT);
                    check(g, "rst_gnt_done_busy", {gnt[0], gnt[1], done[0], done[1], busy}, 0);
                    check(g, "rst_rdata", {rdata[0], rdata[1]}, 0);
                end else begin
                    idle = (cyc >= nfree);
                    check(g, "busy", busy, !idle);
                    if (idle && (req[0] || req[1])) begin
                        w = (req[0] && !(req[1] && run == MB)) ? 0 : 1;
                        check(g, "gnt_pair", {gnt[0], gnt[1]}, (w == 0) ? 2'b10 : 2'b01);
                        if (w == 0) run = req[1] ? ((run < MB) ? run + 1 : run) : 0;
                        else        run = 0;
                        e.m    = w;
                        e.dcyc = cyc + AC + 1;
                        e.rd   = !we[w];
                        e.data = ref_mem.exists(int'(addr[w])) ? ref_mem[int'(addr[w])] : 16'h0;
                        expq.push_back(e);
                        if (we[w]) ref_mem[int'(addr[w])] = wdata[w];
                        act_s = cyc + 1; act_e = cyc + AC;
                        act_we = we[w]; act_a = addr[w]; act_d = wdata[w];
                        nfree = cyc + AC + 1;
                        gnt_log.push_back(w);
                        last_gnt[w] = cyc;
                    end else begin
                        check(g, "no_gnt", {gnt[0], gnt[1]}, 2'b00);
                    end
                    if (cyc >= act_s && cyc <= act_e) begin
                        check(g, "pins_active", pins, act_we ? SRAM_WRITE : SRAM_READ);
                        check(g, "sram_addr", sa, act_a);
                        if (act_we) check(g, "dq_write", dq, act_d);
                    end else begin
                        check(g, "pins_idle", pins, SRAM_NOT_SELECT);
                    end
                    if (done[0] || done[1]) begin
                        if (expq.size() == 0) begin
                            check(g, "unexpected_done", {done[0], done[1]}, 2'b00);
                        end else begin
                            e = expq.pop_front();
                            check(g, "done_owner", {done[0], done[1]}, (e.m == 0) ? 2'b10 : 2'b01);
                            check(g, "done_cycle", cyc, e.dcyc);
                            last_done[e.m] = cyc;
                            if (e.rd) held[e.m] = e.data;
                        end
                    end else if (expq.size() > 0 && expq[0].dcyc <= cyc) begin
                        e = expq.pop_front();
                        check(g, "done_missing", {done[0], done[1]}, (e.m == 0) ? 2'b10 : 2'b01);
                    end
                    check(g, "rdata0", rdata[0], held[0]);
                    check(g, "rdata1", rdata[1], held[1]);
                end
            end
        end

        // Raise a request (called just after a rising edge), wait for its grant, then drop and scramble fields.
        task automatic do_req(input int m, input logic w, input logic [19:0] a, input logic [15:0] d);
            int n = 0;
            req[m] = 1'b1; we[m] = w; addr[m] = a; wdata[m] = d;
            do begin
                @(negedge clk);
                n++;
            end while (!gnt[m] && n < 300);
            if (!gnt[m]) check(g, "gnt_timeout", gnt[m], 1);
            @(posedge clk);
            #1;
            req[m] = 1'b0; we[m] = 1'($urandom); addr[m] = 20'($urandom); wdata[m] = 16'($urandom);
        endtask

        task automatic wait_idle();
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while ((busy || expq.size() != 0) && n < 300);
            if (busy) check(g, "idle_timeout", busy, 0);
            @(posedge clk);
            #1;
        endtask

        task automatic rnd_master(input int m, input int cnt);
            for (int i = 0; i < cnt; i++) begin
                int          k;
                logic        w;
                logic [19:0] a;
                k = $urandom_range(0, 3);
                if (k > 0) begin
                    repeat (k) @(posedge clk);
                    #1;
                end
                w = (wlist.size() == 0) || ($urandom_range(0, 1) == 1);
                k = $urandom_range(0, 15);
                if (w) a = ($urandom_range(0, 1) == 1) ? (20'hFFFF0 | 20'(k)) : 20'(k);
                else   a = wlist[$urandom_range(0, wlist.size() - 1)];
                do_req(m, w, a, 16'($urandom));
                if (w) wlist.push_back(a);
            end
        endtask

        initial begin
            int idx;
            rst = 1'b1;
            req[0] = 0; req[1] = 0; we[0] = 0; we[1] = 0;
            addr[0] = 0; addr[1] = 0; wdata[0] = 0; wdata[1] = 0;
            repeat (3) @(posedge clk);
            #1 rst = 1'b0;

            // M0 write then read back
            do_req(0, 1'b1, 20'h00005, 16'hBEEF);
            wait_idle();
            do_req(0, 1'b0, 20'h00005, 16'h0000);
            wait_idle();
            check(g, "m0_read_beef", rdata[0], 16'hBEEF);

            // M1 write in flight, M0 arrives mid-access
            do_req(1, 1'b1, 20'hFFFFF, 16'h1234);
            do_req(0, 1'b0, 20'h00005, 16'h0000);
            wait_idle();
            check(g, "m0_gnt_at_m1_done", last_gnt[0], last_done[1]);
            wlist.push_back(20'h00005);
            wlist.push_back(20'hFFFFF);

            // Simultaneous reads: M0 first, M1 in M0's done cycle
            fork
                do_req(0, 1'b0, 20'h00005, 16'h0000);
                do_req(1, 1'b0, 20'hFFFFF, 16'h0000);
            join
            wait_idle();
            check(g, "both_reads_span", last_done[1] - last_gnt[0], 2 * (AC + 1));
            check(g, "m1_read_1234", rdata[1], 16'h1234);

            // Continuous M0 traffic with M1 waiting
            gnt_log.delete();
            fork
                for (int i = 0; i < 10; i++) do_req(0, 1'b0, 20'h00005, 16'h0000);
                do_req(1, 1'b0, 20'hFFFFF, 16'h0000);
            join
            wait_idle();
            idx = -1;
            foreach (gnt_log[i]) if (gnt_log[i] == 1 && idx < 0) idx = i;
            check(g, "m1_slot_after_burst", idx, MB);

            // Random traffic from both masters
            fork
                rnd_master(0, 40);
                rnd_master(1, 40);
            join
            wait_idle();

            // Reset during a write access
            do_req(0, 1'b1, 20'h07777, 16'hA5A5);
            repeat (AC - 1) @(posedge clk);
            #1 rst = 1'b1;
            #1 check(g, "rst_async_we_ce", {we_n, ce_n}, 2'b11);
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;
            gnt_log.delete();
            fork
                do_req(0, 1'b0, 20'h00005, 16'h0000);
                do_req(1, 1'b0, 20'h00005, 16'h0000);
            join
            wait_idle();
            check(g, "first_gnt_after_rst", gnt_log.size() > 0 ? gnt_log[0] : -1, 0);
            check(g, "queue_empty", expq.size(), 0);
            fin_l = 1'b1;
        end
    end

    initial begin
        for (int i = 0; i < 20000 && !(cfg[0].fin_l && cfg[1].fin_l); i++) @(posedge clk);
        if (!(cfg[0].fin_l && cfg[1].fin_l)) begin
            n_tests++;
            n_fail++;
            $display("FAIL run_timeout: finished flags %0d%0d, expected 11", cfg[0].fin_l, cfg[1].fin_l);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
Shares the single external 16-bit SRAM between two requesters.
- M0 is the audio record/playback core: high priority, real-time.
- M1 is an auxiliary client, such as a waveform dumper or length/header updater.
Each access is a fixed-length transaction sequenced by a small FSM that owns every SRAM pin. A bounded-starvation rule guarantees M1 progress under continuous M0 traffic.

Parameters:
ACCESS_CYCLES, 2, cycles the SRAM pins are held active per access (1..7)
MAX_M0_BURST, 4, max consecutive M0 grants while M1 is waiting (1..15)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-high
i_m0_req  in  1  M0 request; held until o_m0_gnt
i_m0_we  in  1  M0 1=write, 0=read
i_m0_addr  in  20  M0 word address
i_m0_wdata  in  16  M0 write data
o_m0_gnt  out  1  one-cycle pulse: M0 command accepted
o_m0_done  out  1  one-cycle pulse: M0 access complete
o_m0_rdata  out  16  M0 read data, valid with o_m0_done on reads
i_m1_req, i_m1_we, i_m1_addr, i_m1_wdata, o_m1_gnt, o_m1_done, o_m1_rdata: same as M0, for M1
o_busy  out  1  FSM not in IDLE
SRAM_DQ  inout  16  SRAM data bus
SRAM_ADDR  out  20  SRAM address
SRAM_WE_N, SRAM_CE_N, SRAM_OE_N, SRAM_LB_N, SRAM_UB_N  out  1 each  SRAM controls

Behaviour:
- Reset values:
  - FSM = IDLE; gnt, done, busy = 0; rdata = 0; streak = 0.
  - SRAM_ADDR = 0; SRAM_CE_N = SRAM_WE_N = SRAM_OE_N = 1; LB_N = UB_N = 0; DQ = Z.
- FSM states: IDLE, ACCESS.
- IDLE:
  - If any request is present, arbitrate and pulse the winner's gnt in that cycle.
  - Latch {owner, we, addr, wdata}, load the cycle counter with ACCESS_CYCLES-1, go to ACCESS.
- Arbitration:
  - M0 wins, unless both requests are high and streak == MAX_M0_BURST; then M1 wins.
  - Streak update on each grant:
    - M0 granted while i_m1_req=1: streak+1, saturating.
    - M0 granted while i_m1_req=0: streak=0.
    - M1 granted: streak=0.
- ACCESS (all pins registered from the latched command):
  - SRAM_CE_N=0, LB_N=UB_N=0, SRAM_ADDR=latched addr.
  - Write: WE_N=0, OE_N=1, DQ driven with latched wdata.
  - Read: WE_N=1, OE_N=0, DQ=Z.
  - Counter decrements each cycle.
  - When counter == 0:
    - On a read, capture SRAM_DQ into the owner's rdata register.
    - Pulse the owner's done next cycle; return to IDLE.
- Timing:
  - Grant in cycle t; pins active t+1 .. t+ACCESS_CYCLES; done in cycle t+ACCESS_CYCLES+1, with pins deselected.
  - The IDLE done-cycle may grant the next request, so back-to-back throughput is one access per ACCESS_CYCLES+1 cycles.
  - The deselected cycle is the mandatory bus-turnaround gap.
- DQ is driven only while in ACCESS with a latched write; otherwise Z in every state. No write-to-read overlap is possible.
- rdata registers hold their value until the next read completes for the same master. Writes never alter rdata.
- A request dropped before gnt is lost without effect.
- Request fields are sampled only in the gnt cycle; changes afterwards are ignored.
- A requester may re-assert req in its done cycle and is eligible for grant in that same cycle.
- i_rst mid-ACCESS: pins return to deselected and DQ to Z asynchronously; no done pulse; the in-flight write may be partial.

Decomposition:
- Package sram_arb_pkg holds:
  - typedef sram_cmd_t {we, addr[19:0], wdata[15:0]};
  - enum arb_state_t {IDLE, ACCESS};
  - localparam 5-bit pin modes SRAM_NOT_SELECT / SRAM_READ / SRAM_WRITE as {WE_N, CE_N, OE_N, LB_N, UB_N};
  - localparam OWNER_M0 = 0, OWNER_M1 = 1.
- Sub-module sram_arb_pick holds the grant decision and streak counter: inputs req0, req1, grant-enable; outputs grant0, grant1. It is the natural unit-test target.

Test Plan:
- Single M0 write then read (write addr=0x00005 data=0xBEEF; read addr=0x00005):
  - Write: gnt at t, WE_N low t+1..t+2, done at t+3.
  - Read: o_m0_rdata=0xBEEF with o_m0_done at t+3.
- M0 and M1 read requests first asserted in the same cycle, streak=0 → M0 granted. M1 granted in M0's done cycle (if M0 has dropped req). Total 6 cycles for both.
- M0 requests continuously with M1 held high, MAX_M0_BURST=4 → grant sequence M0, M0, M0, M0, M1, M0, … M1 is never waiting more than 4 M0 accesses.
- M1 write (addr=0xFFFFF, data=0x1234) in flight, M0 requests mid-access → M0 gnt only in M1's done cycle. DQ=0x1234 only during ACCESS and Z in the gap.
- Assert i_rst in the 2nd ACCESS cycle of a write → same cycle: CE_N=WE_N=1, DQ=Z. No done pulse. After release, the first grant goes to M0 and streak=0.
- ACCESS_CYCLES=1 with back-to-back reads → one done every 2 cycles. rdata matches memory model; no DQ contention flagged by the bench's bus monitor.
